// File: rtl/transpose_pkg.sv
// Shared types and width helpers for the transposer and its row streamer.
// Element/line typedefs describe the default Q4.16, 8-element configuration.
package transpose_pkg;

  localparam int unsigned IL_DEF  = 4;
  localparam int unsigned FL_DEF  = 16;
  localparam int unsigned ROW_DEF = 8;
  localparam int unsigned COL_DEF = 8;

  // Element width of a Q IL.FL fixed-point value (sign bit counted in IL).
  function automatic int unsigned elem_width(input int unsigned il, input int unsigned fl);
    return il + fl;
  endfunction

  typedef logic signed [elem_width(IL_DEF, FL_DEF)-1:0] elem_t;
  typedef elem_t [ROW_DEF-1:0] line_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/transpose_line_mux.sv
// Combinational line selector: picks line sel_i of the held tile.
// With TRANSPOSE_STREAM_RELU_EN defined, negative elements are forced to zero.
module transpose_line_mux
  import transpose_pkg::*;
#(
  parameter  int unsigned W      = elem_width(IL_DEF, FL_DEF),
  parameter  int unsigned row    = ROW_DEF,
  parameter  int unsigned col    = COL_DEF,
  localparam int unsigned LINE_W = W * row,
  localparam int unsigned TILE_W = LINE_W * col,
  localparam int unsigned IDX_W  = $clog2(col)
) (
  input  logic [TILE_W-1:0] tile_i,
  input  logic [IDX_W-1:0]  sel_i,
  output logic [LINE_W-1:0] line_c
);

  logic [LINE_W-1:0] raw_line;

  // Compare-based select keeps out-of-range indices (non-power-of-two col) at zero.
  always_comb begin
    raw_line = '0;
    for (int k = 0; k < int'(col); k++) begin
      if (sel_i == IDX_W'(k)) begin
        raw_line = tile_i[k*LINE_W +: LINE_W];
      end
    end
  end

`ifdef TRANSPOSE_STREAM_RELU_EN
  always_comb begin
    line_c = raw_line;
    for (int m = 0; m < int'(row); m++) begin
      if (raw_line[m*W + W - 1]) begin
        line_c[m*W +: W] = '0;
      end
    end
  end
`else
  always_comb begin
    line_c = raw_line;
  end
`endif

endmodule

// File: rtl/transpose_row_streamer.sv
// Captures a transposed tile, acknowledges it with tile_taken, then streams one
// line per valid/ready beat. Optional ReLU on the output: TRANSPOSE_STREAM_RELU_EN.
module transpose_row_streamer
  import transpose_pkg::*;
#(
  parameter  int unsigned IL     = IL_DEF,
  parameter  int unsigned FL     = FL_DEF,
  parameter  int unsigned row    = ROW_DEF,
  parameter  int unsigned col    = COL_DEF,
  localparam int unsigned W      = elem_width(IL, FL),
  localparam int unsigned LINE_W = W * row,
  localparam int unsigned TILE_W = LINE_W * col,
  localparam int unsigned IDX_W  = $clog2(col)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tile_valid,
  input  logic [TILE_W-1:0] tile_in,
  output logic              tile_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(col - 1);

  // col >= 2 guarantees the lingering upstream tile_valid cycle lands in STREAM.
  if (col < 2) begin : g_col_check
    $error("transpose_row_streamer: col must be >= 2");
  end

  state_e            state_q, state_d;
  logic [TILE_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              taken_q, taken_d;
  logic [LINE_W-1:0] line_sel;
  logic              capture;
  logic              beat;

  assign capture = (state_q == IDLE) && tile_valid;
  assign beat    = (state_q == STREAM) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tile_valid) state_d = STREAM;
      STREAM:  if (out_ready && (idx_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer, line counter and the one-cycle capture acknowledge.
  always_comb begin
    buf_d   = buf_q;
    idx_d   = idx_q;
    taken_d = 1'b0;
    if (capture) begin
      buf_d   = tile_in;
      idx_d   = '0;
      taken_d = 1'b1;
    end else if (beat) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      idx_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      taken_q <= taken_d;
    end
  end

  transpose_line_mux #(
    .W   (W),
    .row (row),
    .col (col)
  ) u_line_mux (
    .tile_i (buf_q),
    .sel_i  (idx_q),
    .line_c (line_sel)
  );

  always_comb begin
    tile_taken = taken_q;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    out_index  = idx_q;
    if (state_q == STREAM) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (idx_q == LAST_IDX);
      out_data  = line_sel;
    end
  end

endmodule

// File: tb/tb_transpose_row_streamer.sv
// Randomized bench for transpose_row_streamer against a queue-based line scoreboard.
module tb_transpose_row_streamer;
  import transpose_pkg::*;

  localparam int unsigned IL     = 4;
  localparam int unsigned FL     = 16;
  localparam int unsigned ROW    = 8;
  localparam int unsigned COL    = 8;
  localparam int unsigned W      = elem_width(IL, FL);
  localparam int unsigned LINE_W = W * ROW;
  localparam int unsigned TILE_W = LINE_W * COL;
  localparam int unsigned IDX_W  = $clog2(COL);

  logic              clk;
  logic              reset;
  logic              tile_valid;
  logic [TILE_W-1:0] tile_in;
  logic              tile_taken;
  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;
  logic              busy;

  transpose_row_streamer #(
    .IL  (IL),
    .FL  (FL),
    .row (ROW),
    .col (COL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tile_valid (tile_valid),
    .tile_in    (tile_in),
    .tile_taken (tile_taken),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] data;
    int                idx;
  } beat_t;

  beat_t             exp_q[$];
  logic [W-1:0]      elem_m[COL][ROW];
  int                total;
  int                bad;
  int                dut_taken;
  int                dut_beats;
  logic [LINE_W-1:0] line_const;
  logic [W-1:0]      neg5;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] out_elem(input logic [W-1:0] e);
`ifdef TRANSPOSE_STREAM_RELU_EN
    if ($signed(e) < 0) return '0;
`endif
    return e;
  endfunction

  // mode 0: k+m, 1: k*m, 2: random, 3: alternating -5 / 7
  task automatic set_tile(input int mode);
    for (int k = 0; k < int'(COL); k++) begin
      for (int m = 0; m < int'(ROW); m++) begin
        case (mode)
          0:       elem_m[k][m] = W'(k + m);
          1:       elem_m[k][m] = W'(k * m);
          2:       elem_m[k][m] = W'($urandom);
          default: elem_m[k][m] = (m % 2 == 0) ? neg5 : W'(7);
        endcase
        tile_in[(k*int'(ROW) + m)*int'(W) +: W] = elem_m[k][m];
      end
    end
  endtask

  // One clock: advance the scoreboard with the inputs seen at the edge, then compare.
  task automatic cycle();
    logic         tv;
    logic         rdy;
    logic         was_empty;
    logic         taken_exp;
    logic [W-1:0] snap[COL][ROW];
    beat_t        b;
    tv        = tile_valid;
    rdy       = out_ready;
    snap      = elem_m;
    was_empty = (exp_q.size() == 0);
    if (out_valid && out_ready) dut_beats++;
    @(posedge clk);
    #1;
    taken_exp = 1'b0;
    if (!was_empty) begin
      if (rdy) void'(exp_q.pop_front());
    end else if (tv) begin
      taken_exp = 1'b1;
      for (int k = 0; k < int'(COL); k++) begin
        b.idx = k;
        for (int m = 0; m < int'(ROW); m++) b.data[m*int'(W) +: W] = out_elem(snap[k][m]);
        exp_q.push_back(b);
      end
    end
    if (tile_taken) dut_taken++;
    check("tile_taken", LINE_W'(tile_taken), LINE_W'(taken_exp));
    check("out_valid", LINE_W'(out_valid), LINE_W'(exp_q.size() != 0));
    check("busy", LINE_W'(busy), LINE_W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0].data);
      check("out_index", LINE_W'(out_index), LINE_W'(exp_q[0].idx));
      check("out_last", LINE_W'(out_last), LINE_W'(exp_q[0].idx == int'(COL) - 1));
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) cycle();
    check("drain_done", LINE_W'(exp_q.size() == 0), LINE_W'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, LINE_W'(out_valid), '0);
    check({tag, "_taken"}, LINE_W'(tile_taken), '0);
    check({tag, "_busy"}, LINE_W'(busy), '0);
    check({tag, "_last"}, LINE_W'(out_last), '0);
    check({tag, "_index"}, LINE_W'(out_index), '0);
    check({tag, "_data"}, out_data, '0);
  endtask

  initial begin
    total = 0; bad = 0; dut_taken = 0; dut_beats = 0;
    neg5 = W'(-5);
    reset = 1'b0; tile_valid = 1'b0; out_ready = 1'b0; tile_in = '0;
    set_tile(0);
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // k+m tile, tile_valid held two cycles, full throughput
    set_tile(0);
    for (int m = 0; m < int'(ROW); m++) line_const[m*int'(W) +: W] = W'(3 + m);
    tile_valid = 1'b1; out_ready = 1'b1;
    cycle();
    cycle();
    tile_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_index == IDX_W'(3)) check("line3", out_data, line_const);
      cycle();
    end
    check("one_tile", LINE_W'(dut_taken), LINE_W'(1));
    check("eight_beats", LINE_W'(dut_beats), LINE_W'(COL));

    // stall pattern 1,0,0,1
    dut_beats = 0;
    tile_valid = 1'b1;
    cycle();
    tile_valid = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    check("stall_drained", LINE_W'(exp_q.size() == 0), LINE_W'(1));
    check("stall_beats", LINE_W'(dut_beats), LINE_W'(COL));

    // back-to-back: second tile presented right after the last beat
    out_ready = 1'b1;
    tile_valid = 1'b1;
    cycle();
    tile_valid = 1'b0;
    drain(20);
    set_tile(1);
    for (int m = 0; m < int'(ROW); m++) line_const[m*int'(W) +: W] = W'(2 * m);
    tile_valid = 1'b1;
    cycle();
    tile_valid = 1'b0;
    check("b2b_first_idx", LINE_W'(out_index), '0);
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_index == IDX_W'(2)) check("line2", out_data, line_const);
      cycle();
    end

    // reset after 3 beats
    set_tile(2);
    dut_taken = 0;
    tile_valid = 1'b1;
    cycle();
    tile_valid = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) cycle();
    check("midrst_no_taken", LINE_W'(dut_taken), LINE_W'(1));

    // -5 / 7 elements
    set_tile(3);
    tile_valid = 1'b1;
    cycle();
    tile_valid = 1'b0;
`ifdef TRANSPOSE_STREAM_RELU_EN
    check("relu_neg", LINE_W'(out_data[W-1:0]), '0);
`else
    check("relu_neg", LINE_W'(out_data[W-1:0]), LINE_W'(20'hFFFFB));
`endif
    check("relu_pos", LINE_W'(out_data[2*W-1:W]), LINE_W'(7));
    drain(20);

    // idle with out_ready high
    dut_taken = 0;
    out_ready = 1'b1;
    repeat (20) cycle();
    check("idle_no_taken", LINE_W'(dut_taken), '0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tile_valid = ($urandom_range(0, 2) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) set_tile(2);
      cycle();
    end
    tile_valid = 1'b0;
    out_ready  = 1'b1;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_row_streamer.md
Name: transpose_row_streamer

Overview:
- Downstream stage of the transposer; consumes one completed transposed tile (col lines x row elements, fixed-point Q IL.FL).
- Captures the tile into a local buffer, releases the transposer with a one-cycle tile_taken pulse, then streams the tile one line per beat to the next stage over a valid/ready link.
- Frees the transposer to start its next tile while the current tile is still draining.

Parameters:
- IL, 4, integer bits per element (sign included).
- FL, 16, fractional bits per element; element width W = IL+FL.
- row, 8, elements per output line (source row count).
- col, 8, output lines per tile (source column count); must be >= 2, elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tile_valid  in  1  transposer holds a finished tile on tile_in.
- tile_in  in  W*row*col  transposed tile; element [k][m] (k<col, m<row) at bits ((k*row+m)*W) +: W, signed.
- tile_taken  out  1  one-cycle pulse: tile captured, upstream may advance (drives transposer output_taken).
- out_valid  out  1  out_data holds a valid line.
- out_ready  in  1  downstream accepts the line this cycle.
- out_data  out  W*row  line k; element m at bits (m*W) +: W.
- out_index  out  $clog2(col)  line number k of the current beat.
- out_last  out  1  high with out_valid on line col-1.
- busy  out  1  high while a tile is held (STREAM state).

Behaviour:
- Reset (async assert, sync release): state IDLE; tile_taken, out_valid, out_last, busy, out_index, out_data all 0; buffer cleared to 0.
- States: IDLE, STREAM.
- IDLE: on a clock edge with tile_valid=1, buffer <= tile_in, index <= 0, state -> STREAM. tile_taken = 1 for exactly the following cycle.
- STREAM: out_valid=1, busy=1, out_data = buffer line index, out_index = index, out_last = (index==col-1).
- Beat fires on an edge with out_valid & out_ready. A non-last beat gives index+1. The last beat returns the state to IDLE, where out_valid=0 the next cycle.
- Backpressure: while out_ready=0, out_data/out_index/out_last are held stable. out_valid never drops mid-tile.
- tile_valid is ignored in STREAM. Upstream still shows tile_valid for one cycle after capture; col>=2 guarantees this cycle is not re-captured.
- Back-to-back: tile_valid sampled in IDLE on the cycle right after the last beat is captured. Peak throughput is col beats per tile plus 1 idle cycle.
- Latency: tile_valid edge N -> first out_valid in cycle N+1 (same cycle as tile_taken).
- Reset mid-stream: tile is dropped, no further beats, no tile_taken.
- out_ready while out_valid=0 has no effect.
- Data is passed bit-exact, with no arithmetic unless the optional feature is enabled.

Optional Feature:
- Macro TRANSPOSE_STREAM_RELU_EN.
- Defined: each element of out_data is replaced with 0 when its sign bit is 1. Applied combinationally on the output mux; the buffer stays raw. Width is unchanged.
- Undefined: elements pass unmodified, and no ReLU logic is instantiated.

Decomposition:
- Shared package (transpose_pkg) holds:
  - W = IL+FL as a localparam function;
  - a typedef for a signed element;
  - a typedef for a line (row elements);
  - the state enum {IDLE, STREAM}.
- The transposer and this block both import the package.
- One natural sub-module: transpose_line_mux. It is combinational and selects line out_index from the buffer, applying the optional ReLU.

Test Plan:
- Reset then tile_in[k][m]=k+m, tile_valid held 2 cycles, out_ready=1 -> tile_taken single pulse; lines 0..7 on 8 consecutive cycles, line 3 = {3,4,...,10}; out_last only on index 7; exactly one tile captured.
- Same tile, out_ready toggled 1,0,0,1... -> out_data/out_index stable during stalls; 8 beats total; no skipped or repeated index.
- Second tile (k*m) with tile_valid asserted right after the first tile's last beat -> captured in the next cycle; first beat index 0, line 2 = {0,2,4,...,14}.
- Reset asserted after 3 beats -> outputs 0 immediately (async); after release, IDLE, no tile_taken, out_valid=0.
- With TRANSPOSE_STREAM_RELU_EN, element = -5 (20'hFFFFB) and 7 -> out 0 and 7; without the macro -> 20'hFFFFB and 7.
- Idle, tile_valid=0, out_ready=1 for 20 cycles -> out_valid, tile_taken and busy stay 0.
